// File: rtl/ysyx_2022040010_id_hazard_pkg.sv
// Shared widths, bus field positions and FSM encodings for the ID-stage
// bypass / load-use hazard unit.
package ysyx_2022040010_id_hazard_pkg;

    localparam int DATA_W  = 64;
    localparam int REG_AW  = 5;
    localparam int FWD_W   = 70;
    localparam int LOAD_W  = 7;

    // Forwarding bus: {we, waddr[4:0], wdata[63:0]}
    localparam int FWD_WE_BIT    = 69;
    localparam int FWD_WADDR_HI  = 68;
    localparam int FWD_WADDR_LO  = 64;
    localparam int FWD_WDATA_HI  = 63;
    localparam int FWD_WDATA_LO  = 0;

    // Load descriptor: {waddr[4:0], dram_we, dram_e}
    localparam int LD_WADDR_HI   = 6;
    localparam int LD_WADDR_LO   = 2;
    localparam int LD_DRAM_WE    = 1;
    localparam int LD_DRAM_E     = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } hazard_state_e;

    // A source hits a producer when it is read, is not x0, and the producer
    // writes the same register.
    function automatic logic src_match(input logic              re,
                                       input logic [REG_AW-1:0] addr,
                                       input logic              we,
                                       input logic [REG_AW-1:0] waddr);
        return re & (addr != '0) & we & (waddr == addr);
    endfunction

endpackage

// File: rtl/ysyx_2022040010_fwd_mux.sv
// Per-source operand select. Priority: held load data, EX, returning load
// data, EX->MEM (skipped while it carries a load), MEM->WB, regfile.
// x0 always reads as zero.
module ysyx_2022040010_fwd_mux
    import ysyx_2022040010_id_hazard_pkg::*;
(
    input  logic              rs_re,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [DATA_W-1:0] rf_rdata,
    input  logic [FWD_W-1:0]  ex_bus,
    input  logic              ex_is_load,
    input  logic [FWD_W-1:0]  e2m_bus,
    input  logic [FWD_W-1:0]  m2w_bus,
    input  logic              mem_load,
    input  logic [REG_AW-1:0] load_waddr,
    input  logic              mem_load_valid,
    input  logic [DATA_W-1:0] mem_load_data,
    input  logic              hold_active,
    input  logic [REG_AW-1:0] hold_waddr,
    input  logic [DATA_W-1:0] hold_data,
    output logic [DATA_W-1:0] data,
    output logic              ex_load_hazard,
    output logic              mem_load_hazard
);

    logic ex_hit;
    logic e2m_hit;
    logic m2w_hit;
    logic load_hit;
    logic hold_hit;

    // Match each producer against this source.
    always_comb begin
        ex_hit   = src_match(rs_re, rs_addr, ex_bus[FWD_WE_BIT],
                             ex_bus[FWD_WADDR_HI:FWD_WADDR_LO]);
        e2m_hit  = src_match(rs_re, rs_addr, e2m_bus[FWD_WE_BIT],
                             e2m_bus[FWD_WADDR_HI:FWD_WADDR_LO]) & ~mem_load;
        m2w_hit  = src_match(rs_re, rs_addr, m2w_bus[FWD_WE_BIT],
                             m2w_bus[FWD_WADDR_HI:FWD_WADDR_LO]);
        load_hit = src_match(rs_re, rs_addr, mem_load, load_waddr);
        hold_hit = src_match(rs_re, rs_addr, hold_active, hold_waddr);
    end

    // Priority select of the operand value.
    always_comb begin
        data = rf_rdata;
        if (rs_addr == '0)
            data = '0;
        else if (hold_hit)
            data = hold_data;
        else if (ex_hit)
            data = ex_bus[FWD_WDATA_HI:FWD_WDATA_LO];
        else if (load_hit && mem_load_valid)
            data = mem_load_data;
        else if (e2m_hit)
            data = e2m_bus[FWD_WDATA_HI:FWD_WDATA_LO];
        else if (m2w_hit)
            data = m2w_bus[FWD_WDATA_HI:FWD_WDATA_LO];
    end

    // Hazard flags reported to the FSM.
    always_comb begin
        ex_load_hazard  = ex_is_load & ex_hit;
        mem_load_hazard = load_hit;
    end

endmodule

// File: rtl/ysyx_2022040010_id_hazard.sv
// ID-stage operand bypass and load-use hazard unit.
// Optional feature: YSYX_HAZARD_PERF_EN adds perf_load_stall_cnt, a wrapping
// count of cycles with stallreq_for_load asserted (cleared by rst only).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no load outstanding for ID; bypass from buses/regfile
// WAIT    | ID needs a MEM load whose data has not returned; stall
// HOLD    | load data captured while ID is held; forward it from hold reg
module ysyx_2022040010_id_hazard
    import ysyx_2022040010_id_hazard_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic              rs1_re,
    input  logic              rs2_re,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic [FWD_W-1:0]  ex_fwd_bus,
    input  logic              ex_is_load,
    input  logic [FWD_W-1:0]  e2m_fwd_bus,
    input  logic [LOAD_W-1:0] e2m_load_info,
    input  logic [FWD_W-1:0]  m2w_fwd_bus,
    input  logic              mem_load_valid,
    input  logic [DATA_W-1:0] mem_load_data,
    output logic [DATA_W-1:0] src1_data,
    output logic [DATA_W-1:0] src2_data,
    output logic              stallreq_for_load
`ifdef YSYX_HAZARD_PERF_EN
   ,output logic [31:0]       perf_load_stall_cnt
`endif
);

    hazard_state_e     state;
    logic              hold_valid;
    logic [REG_AW-1:0] hold_waddr;
    logic [DATA_W-1:0] hold_data;

    logic              mem_load;
    logic [REG_AW-1:0] load_waddr;
    logic              hold_active;
    logic              id_held;
    logic              ex_haz1, ex_haz2;
    logic              mem_haz1, mem_haz2;
    logic              ex_hazard;
    logic              mem_hazard;

    // Only stall[2] matters here; the other stage bits are ignored.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5:3], stall[1:0]};

    // Decode the load descriptor and the hold-forwarding enable.
    always_comb begin
        mem_load    = e2m_load_info[LD_DRAM_E] & ~e2m_load_info[LD_DRAM_WE];
        load_waddr  = e2m_load_info[LD_WADDR_HI:LD_WADDR_LO];
        hold_active = (state == ST_HOLD) & hold_valid;
        id_held     = stall[2];
    end

    ysyx_2022040010_fwd_mux u_fwd_src1 (
        .rs_re           (rs1_re),
        .rs_addr         (rs1_addr),
        .rf_rdata        (rf_rdata1),
        .ex_bus          (ex_fwd_bus),
        .ex_is_load      (ex_is_load),
        .e2m_bus         (e2m_fwd_bus),
        .m2w_bus         (m2w_fwd_bus),
        .mem_load        (mem_load),
        .load_waddr      (load_waddr),
        .mem_load_valid  (mem_load_valid),
        .mem_load_data   (mem_load_data),
        .hold_active     (hold_active),
        .hold_waddr      (hold_waddr),
        .hold_data       (hold_data),
        .data            (src1_data),
        .ex_load_hazard  (ex_haz1),
        .mem_load_hazard (mem_haz1)
    );

    ysyx_2022040010_fwd_mux u_fwd_src2 (
        .rs_re           (rs2_re),
        .rs_addr         (rs2_addr),
        .rf_rdata        (rf_rdata2),
        .ex_bus          (ex_fwd_bus),
        .ex_is_load      (ex_is_load),
        .e2m_bus         (e2m_fwd_bus),
        .m2w_bus         (m2w_fwd_bus),
        .mem_load        (mem_load),
        .load_waddr      (load_waddr),
        .mem_load_valid  (mem_load_valid),
        .mem_load_data   (mem_load_data),
        .hold_active     (hold_active),
        .hold_waddr      (hold_waddr),
        .hold_data       (hold_data),
        .data            (src2_data),
        .ex_load_hazard  (ex_haz2),
        .mem_load_hazard (mem_haz2)
    );

    // Stall request: EX load always stalls; MEM load stalls until data returns.
    always_comb begin
        ex_hazard         = ex_haz1 | ex_haz2;
        mem_hazard        = mem_haz1 | mem_haz2;
        stallreq_for_load = ex_hazard;
        case (state)
            ST_IDLE: stallreq_for_load = ex_hazard | (mem_hazard & ~mem_load_valid);
            ST_WAIT: stallreq_for_load = ex_hazard | ~mem_load_valid;
            default: stallreq_for_load = ex_hazard;
        endcase
    end

    // Load-use FSM and hold register; both sources share one capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            hold_valid <= 1'b0;
            hold_waddr <= '0;
            hold_data  <= '0;
        end else if (flush) begin
            state      <= ST_IDLE;
            hold_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_hazard && mem_load_valid) begin
                        if (id_held) begin
                            state      <= ST_HOLD;
                            hold_valid <= 1'b1;
                            hold_waddr <= load_waddr;
                            hold_data  <= mem_load_data;
                        end
                    end else if (mem_hazard) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_load_valid) begin
                        hold_valid <= id_held;
                        hold_waddr <= load_waddr;
                        hold_data  <= mem_load_data;
                        state      <= id_held ? ST_HOLD : ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (!id_held) begin
                        state      <= ST_IDLE;
                        hold_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    hold_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef YSYX_HAZARD_PERF_EN
    // Count load-stall cycles; flush does not clear it.
    always_ff @(posedge clk) begin
        if (rst)
            perf_load_stall_cnt <= '0;
        else if (stallreq_for_load)
            perf_load_stall_cnt <= perf_load_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_ysyx_2022040010_id_hazard.sv
// Directed self-checking bench for the ID-stage hazard unit.
module tb_ysyx_2022040010_id_hazard;
    import ysyx_2022040010_id_hazard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        rs1_re, rs2_re;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [63:0] rf_rdata1, rf_rdata2;
    logic [69:0] ex_fwd_bus;
    logic        ex_is_load;
    logic [69:0] e2m_fwd_bus;
    logic [6:0]  e2m_load_info;
    logic [69:0] m2w_fwd_bus;
    logic        mem_load_valid;
    logic [63:0] mem_load_data;
    logic [63:0] src1_data, src2_data;
    logic        stallreq_for_load;
`ifdef YSYX_HAZARD_PERF_EN
    logic [31:0] perf_load_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_2022040010_id_hazard dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .rs1_re            (rs1_re),
        .rs2_re            (rs2_re),
        .rs1_addr          (rs1_addr),
        .rs2_addr          (rs2_addr),
        .rf_rdata1         (rf_rdata1),
        .rf_rdata2         (rf_rdata2),
        .ex_fwd_bus        (ex_fwd_bus),
        .ex_is_load        (ex_is_load),
        .e2m_fwd_bus       (e2m_fwd_bus),
        .e2m_load_info     (e2m_load_info),
        .m2w_fwd_bus       (m2w_fwd_bus),
        .mem_load_valid    (mem_load_valid),
        .mem_load_data     (mem_load_data),
        .src1_data         (src1_data),
        .src2_data         (src2_data),
        .stallreq_for_load (stallreq_for_load)
`ifdef YSYX_HAZARD_PERF_EN
       ,.perf_load_stall_cnt (perf_load_stall_cnt)
`endif
    );

    function automatic logic [69:0] fbus(input logic we, input logic [4:0] a, input logic [63:0] d);
        return {we, a, d};
    endfunction

    function automatic logic [6:0] linfo(input logic [4:0] a, input logic dwe, input logic de);
        return {a, dwe, de};
    endfunction

    task automatic clear_inputs();
        stall = '0; flush = 0; rs1_re = 0; rs2_re = 0; rs1_addr = 0; rs2_addr = 0;
        rf_rdata1 = 0; rf_rdata2 = 0; ex_fwd_bus = 0; ex_is_load = 0; e2m_fwd_bus = 0;
        e2m_load_info = 0; m2w_fwd_bus = 0; mem_load_valid = 0; mem_load_data = 0;
    endtask

    // Inputs change on the falling edge; checks happen 1 ns later.
    task automatic step();
        @(negedge clk);
    endtask

    // n stall cycles on a load to register a (read via rs2), then data d.
    task automatic run_load(input int n, input logic [4:0] a, input logic [63:0] d, input logic hold_after);
        for (int i = 0; i < n; i++) begin
            step();
            e2m_load_info = linfo(a, 0, 1); e2m_fwd_bus = fbus(1, a, 64'h55);
            rs2_re = 1; rs2_addr = a; rf_rdata2 = 64'h22; mem_load_valid = 0; stall = 6'b000100;
            #1; checks++;
            if (stallreq_for_load !== 1'b1) begin errors++; $display("FAIL load_stall cyc%0d got %b want 1", i, stallreq_for_load); end
        end
        step();
        e2m_load_info = linfo(a, 0, 1); e2m_fwd_bus = fbus(1, a, 64'h55);
        rs2_re = 1; rs2_addr = a; rf_rdata2 = 64'h22;
        mem_load_valid = 1; mem_load_data = d; stall = {3'b000, hold_after, 2'b00};
        #1; checks++;
        if (stallreq_for_load !== 1'b0) begin errors++; $display("FAIL load_valid_stall got %b want 0", stallreq_for_load); end
        checks++;
        if (src2_data !== d) begin errors++; $display("FAIL load_valid_src2 got %h want %h", src2_data, d); end
    endtask

    task automatic test_reset();
        step(); clear_inputs(); rst = 1;
        rs1_re = 1; rs1_addr = 3; rf_rdata1 = 64'h33;
        #1; checks++;
        if (src1_data !== 64'h33) begin errors++; $display("FAIL reset_src1 got %h want 33", src1_data); end
        checks++;
        if (stallreq_for_load !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stallreq_for_load); end
        ex_is_load = 1; ex_fwd_bus = fbus(1, 3, 64'h99);
        #1; checks++;
        if (stallreq_for_load !== 1'b1) begin errors++; $display("FAIL reset_ex_load_stall got %b want 1", stallreq_for_load); end
        ex_is_load = 0; ex_fwd_bus = 0;
        step(); rst = 0; clear_inputs();
        #1; checks++;
        if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want 0", dut.state); end
`ifdef YSYX_HAZARD_PERF_EN
        checks++;
        if (perf_load_stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_perf got %0d want 0", perf_load_stall_cnt); end
`endif
    endtask

    task automatic test_no_hazard();
        step(); clear_inputs();
        rs1_re = 1; rs1_addr = 5; rf_rdata1 = 64'h11;
        ex_fwd_bus = fbus(0, 5, 64'hAA); m2w_fwd_bus = fbus(1, 6, 64'hCC);
        #1; checks++;
        if (src1_data !== 64'h11) begin errors++; $display("FAIL nohaz_src1 got %h want 11", src1_data); end
        checks++;
        if (stallreq_for_load !== 1'b0) begin errors++; $display("FAIL nohaz_stall got %b want 0", stallreq_for_load); end
    endtask

    task automatic test_priority();
        step(); clear_inputs();
        rs1_re = 1; rs1_addr = 5; rf_rdata1 = 64'h11;
        ex_fwd_bus = fbus(1, 5, 64'hAA); e2m_fwd_bus = fbus(1, 5, 64'hBB);
        #1; checks++;
        if (src1_data !== 64'hAA) begin errors++; $display("FAIL prio_ex_over_e2m got %h want aa", src1_data); end
        rs1_addr = 0;
        #1; checks++;
        if (src1_data !== 64'h0) begin errors++; $display("FAIL prio_x0 got %h want 0", src1_data); end
        step(); rs1_addr = 5; ex_fwd_bus = fbus(0, 5, 64'hAA);
        #1; checks++;
        if (src1_data !== 64'hBB) begin errors++; $display("FAIL prio_e2m got %h want bb", src1_data); end
        step(); e2m_fwd_bus = 0; m2w_fwd_bus = fbus(1, 5, 64'hCC);
        #1; checks++;
        if (src1_data !== 64'hCC) begin errors++; $display("FAIL prio_m2w got %h want cc", src1_data); end
        step(); e2m_fwd_bus = fbus(1, 5, 64'hBB); e2m_load_info = linfo(9, 0, 1);
        #1; checks++;
        if (src1_data !== 64'hCC) begin errors++; $display("FAIL prio_e2m_load_skip got %h want cc", src1_data); end
        checks++;
        if (stallreq_for_load !== 1'b0) begin errors++; $display("FAIL prio_other_load_stall got %b want 0", stallreq_for_load); end
        step(); e2m_load_info = linfo(5, 1, 1);
        #1; checks++;
        if (src1_data !== 64'hBB) begin errors++; $display("FAIL prio_store_e2m got %h want bb", src1_data); end
        step(); e2m_load_info = linfo(5, 0, 1); mem_load_valid = 1; mem_load_data = 64'h77;
        #1; checks++;
        if (src1_data !== 64'h77) begin errors++; $display("FAIL prio_memdata got %h want 77", src1_data); end
        step(); ex_fwd_bus = fbus(1, 5, 64'hAA);
        #1; checks++;
        if (src1_data !== 64'hAA) begin errors++; $display("FAIL prio_ex_over_memdata got %h want aa", src1_data); end
        rs1_re = 0;
        #1; checks++;
        if (src1_data !== 64'h11) begin errors++; $display("FAIL prio_re_off got %h want 11", src1_data); end
        step(); clear_inputs();
        #1; checks++;
        if (dut.state !== ST_IDLE) begin errors++; $display("FAIL prio_state got %0d want 0", dut.state); end
    endtask

    task automatic test_mem_load_3cycle();
        run_load(2, 7, 64'hDEAD, 0);
        step(); clear_inputs(); rs2_re = 1; rs2_addr = 7; rf_rdata2 = 64'h22;
        #1; checks++;
        if (src2_data !== 64'h22) begin errors++; $display("FAIL lat3_after_src2 got %h want 22", src2_data); end
        checks++;
        if (dut.state !== ST_IDLE) begin errors++; $display("FAIL lat3_state got %0d want 0", dut.state); end
    endtask

    task automatic test_same_cycle();
        run_load(0, 8, 64'h1234, 0);
        step(); clear_inputs();
        #1; checks++;
        if (dut.state !== ST_IDLE) begin errors++; $display("FAIL samecyc_state got %0d want 0", dut.state); end
    endtask

    task automatic test_hold();
        run_load(2, 7, 64'hDEAD, 1);
        for (int i = 0; i < 2; i++) begin
            step(); clear_inputs(); stall = 6'b000100; rs2_re = 1; rs2_addr = 7; rf_rdata2 = 64'h22;
            #1; checks++;
            if (src2_data !== 64'hDEAD) begin errors++; $display("FAIL hold_src2 cyc%0d got %h want dead", i, src2_data); end
            checks++;
            if (stallreq_for_load !== 1'b0) begin errors++; $display("FAIL hold_stall cyc%0d got %b want 0", i, stallreq_for_load); end
        end
        step(); stall = 0;
        #1; checks++;
        if (src2_data !== 64'hDEAD) begin errors++; $display("FAIL hold_release_src2 got %h want dead", src2_data); end
        step();
        #1; checks++;
        if (src2_data !== 64'h22) begin errors++; $display("FAIL hold_after_src2 got %h want 22", src2_data); end
        checks++;
        if (dut.state !== ST_IDLE) begin errors++; $display("FAIL hold_exit_state got %0d want 0", dut.state); end
    endtask

    task automatic test_both_sources();
        step(); clear_inputs(); rs1_re = 1; rs1_addr = 9; rf_rdata1 = 64'h11;
        run_load(1, 9, 64'hBEEF, 1);
        step(); clear_inputs(); stall = 6'b000100;
        rs1_re = 1; rs1_addr = 9; rf_rdata1 = 64'h11; rs2_re = 1; rs2_addr = 9; rf_rdata2 = 64'h22;
        #1; checks++;
        if (src1_data !== 64'hBEEF) begin errors++; $display("FAIL both_src1 got %h want beef", src1_data); end
        checks++;
        if (src2_data !== 64'hBEEF) begin errors++; $display("FAIL both_src2 got %h want beef", src2_data); end
        step(); stall = 0;
        step(); clear_inputs();
    endtask

    task automatic test_ex_load();
        step(); clear_inputs(); rs1_re = 1; rs1_addr = 4; ex_is_load = 1; ex_fwd_bus = fbus(1, 4, 64'h0);
        stall = 6'b000100;
        #1; checks++;
        if (stallreq_for_load !== 1'b1) begin errors++; $display("FAIL exload_stall got %b want 1", stallreq_for_load); end
        step(); clear_inputs(); rs1_re = 1; rs1_addr = 4;
        e2m_load_info = linfo(4, 0, 1); mem_load_valid = 1; mem_load_data = 64'h4444;
        #1; checks++;
        if (dut.state !== ST_IDLE) begin errors++; $display("FAIL exload_state got %0d want 0", dut.state); end
        checks++;
        if (stallreq_for_load !== 1'b0) begin errors++; $display("FAIL exload_mem_stall got %b want 0", stallreq_for_load); end
        checks++;
        if (src1_data !== 64'h4444) begin errors++; $display("FAIL exload_src1 got %h want 4444", src1_data); end
        step(); clear_inputs();
    endtask

    task automatic test_kill_wait(input logic use_rst);
        step(); clear_inputs(); rs2_re = 1; rs2_addr = 7; e2m_load_info = linfo(7, 0, 1); stall = 6'b000100;
        step(); if (use_rst) rst = 1; else flush = 1;
        #1; checks++;
        if (dut.state !== ST_WAIT) begin errors++; $display("FAIL kill%0d_pre_state got %0d want 1", use_rst, dut.state); end
        checks++;
        if (stallreq_for_load !== 1'b1) begin errors++; $display("FAIL kill%0d_pre_stall got %b want 1", use_rst, stallreq_for_load); end
        step(); rst = 0; clear_inputs(); rs2_re = 1; rs2_addr = 7;
        #1; checks++;
        if (stallreq_for_load !== 1'b0) begin errors++; $display("FAIL kill%0d_stall got %b want 0", use_rst, stallreq_for_load); end
        checks++;
        if (dut.state !== ST_IDLE) begin errors++; $display("FAIL kill%0d_state got %0d want 0", use_rst, dut.state); end
`ifdef YSYX_HAZARD_PERF_EN
        if (use_rst) begin
            checks++;
            if (perf_load_stall_cnt !== 32'd0) begin errors++; $display("FAIL kill_rst_perf got %0d want 0", perf_load_stall_cnt); end
        end
`endif
    endtask

`ifdef YSYX_HAZARD_PERF_EN
    task automatic test_perf();
        run_load(2, 7, 64'h1, 0);
        step(); clear_inputs();
        run_load(3, 6, 64'h2, 0);
        step(); clear_inputs();
        #1; checks++;
        if (perf_load_stall_cnt !== 32'd5) begin errors++; $display("FAIL perf_cnt got %0d want 5", perf_load_stall_cnt); end
    endtask
`endif

    initial begin
        clear_inputs(); rst = 1;
        test_reset();
        test_no_hazard();
        test_priority();
        test_mem_load_3cycle();
        test_same_cycle();
        test_hold();
        test_both_sources();
        test_ex_load();
        test_kill_wait(1'b0);
        test_kill_wait(1'b1);
`ifdef YSYX_HAZARD_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_2022040010_id_hazard.md
# ysyx_2022040010_id_hazard

ID-stage operand bypass and load-use hazard unit. It consumes the write-back forwarding buses published by the EX stage, the EX→MEM pipeline register and the MEM→WB stage. It also consumes the load-descriptor bus from the EX→MEM register. From these it selects the two source operands for decode and raises `stallreq_for_load` until a load's data returns from the AXI data path. It is the receiving end of the `{we, waddr, wdata}` bypass protocol and the `{waddr, dram_we, dram_e}` stall-load protocol.

## Interface
Parameters:
- none. Widths are fixed by the shared defines.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `stall` in 6: pipeline stall vector; `stall[2]` = ID held this cycle.
- `flush` in 1: branch or exception flush of ID/EX/MEM.
- `rs1_re`, `rs2_re` in 1: source-read enables from decode.
- `rs1_addr`, `rs2_addr` in 5: source register numbers.
- `rf_rdata1`, `rf_rdata2` in 64: regfile read data.
- `ex_fwd_bus` in 70: `{we, waddr[4:0], wdata[63:0]}` from EX.
- `ex_is_load` in 1: the EX instruction is a load.
- `e2m_fwd_bus` in 70: `{we, waddr, wdata}` from the EX→MEM register. `we` is already zeroed for x0.
- `e2m_load_info` in 7: `{waddr[4:0], dram_we, dram_e}` from the EX→MEM register.
- `m2w_fwd_bus` in 70: `{we, waddr, wdata}` from MEM→WB.
- `mem_load_valid` in 1: load data valid from the MEM/AXI read path, one-cycle pulse.
- `mem_load_data` in 64: extended load result, valid with `mem_load_valid`.
- `src1_data`, `src2_data` out 64: bypassed operands.
- `stallreq_for_load` out 1: request to stall IF/ID.
- `perf_load_stall_cnt` out 32: present only with `YSYX_HAZARD_PERF_EN`.

## Operation
- Load in MEM: `mem_load = dram_e & ~dram_we`.
- Match rule for source *n*: `rsn_re & (rsn_addr != 0) & bus.we & (bus.waddr == rsn_addr)`.
- Operand priority, highest first:
  - held load data (state HOLD, address match);
  - EX bus;
  - `mem_load_data` (when `mem_load_valid` and the address matches the MEM load);
  - e2m bus (only if not `mem_load`);
  - m2w bus;
  - regfile.
- `rsn_addr == 0` always yields 0.
- EX-load hazard: `ex_is_load` and an EX match. Stall combinationally; the state stays IDLE. The next cycle this becomes a MEM-load hazard.
- MEM-load hazard: `mem_load` and a source matches `e2m_load_info.waddr`.
- FSM states:
  - **IDLE.**
    - MEM-load hazard with `mem_load_valid`=1: forward `mem_load_data` directly. If `stall[2]`, capture it into the hold register and go to HOLD. Otherwise stay IDLE. No stall.
    - MEM-load hazard with `mem_load_valid`=0: stall and go to WAIT.
  - **WAIT.**
    - `stallreq_for_load`=1 until `mem_load_valid`.
    - On `mem_load_valid`: capture the data and `waddr` into the hold register, deassert the stall in that same cycle, and forward directly. Then go to HOLD if `stall[2]`, else to IDLE.
  - **HOLD.**
    - Forward the held data for matching sources; no load stall.
    - Return to IDLE on the first cycle with `stall[2]`=0.
- `flush` or `rst`: next state is IDLE and the hold-valid flag is cleared, from any state including mid-WAIT. The hold register is zeroed on `rst` only.
- Both sources matching the same load: a single capture, and both operands use it.

## Timing
- Operand select and `stallreq_for_load` are combinational from inputs and the current state. Zero-cycle bypass latency.
- State, hold register and counter update on `posedge clk`.
- Reset values:
  - state = IDLE;
  - hold data and hold waddr = 0;
  - `perf_load_stall_cnt` = 0.
- Output values in reset:
  - `stallreq_for_load` = 0 while the state is IDLE, unless an EX-load hazard is presented.
  - The operands follow their inputs.
- Stall length for a MEM-load hazard equals the AXI read latency in cycles. A same-cycle `mem_load_valid` gives 0 stall cycles.
- EX-load hazard: at least 1 stall cycle, followed by the MEM-load rules.

## Configuration
- `YSYX_HAZARD_PERF_EN` defined:
  - `perf_load_stall_cnt` increments by 1 on every cycle with `stallreq_for_load`=1;
  - it wraps at 2^32;
  - it is cleared only by `rst`, not by `flush`.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Shared defines:
  - fwd-bus width 70;
  - load-info width 7;
  - field bit ranges;
  - FSM state encodings (IDLE=2'd0, WAIT=2'd1, HOLD=2'd2).
- One sub-module, `ysyx_2022040010_fwd_mux`, instantiated once per source. It takes the address, read enable, three buses, the load and hold inputs and the regfile data, and outputs the data plus a hazard flag.

## Test plan
- **No hazard.** rs1=5 with `rf_rdata1`=0x11 and no bus matches → `src1_data`=0x11, stall=0.
- **EX over e2m priority.** EX bus `{1,5,0xAA}` and e2m bus `{1,5,0xBB}` with rs1=5 → `src1_data`=0xAA. With `rs1_addr`=0 → `src1_data`=0.
- **MEM load, 3-cycle latency.** Load to x7, rs2=7, `mem_load_valid` on the 3rd cycle with data 0xDEAD:
  - `stallreq_for_load`=1 for 2 cycles;
  - `src2_data`=0xDEAD in the valid cycle.
- **HOLD.** As the previous case, but with `stall[2]`=1 for 2 more cycles after `mem_load_valid` → `src2_data` stays 0xDEAD, and the FSM returns to IDLE when `stall[2]` drops.
- **Flush and reset in WAIT.** `flush` pulse while in WAIT → stall=0 next cycle and state IDLE. Repeat with `rst` → same, and the counter reads 0.
- **Perf counter.** With `YSYX_HAZARD_PERF_EN`, two load hazards of 2 and 3 stall cycles → `perf_load_stall_cnt`=5.
